lif_neuron: RTL and testbench

- Single leaky integrate-and-fire neuron; sits directly downstream of a bank of N_IN Poisson encoders and consumes their spike_out/spike_valid pairs.
- Each valid input spike adds a programmable signed synaptic weight to the membrane potential.
- Each enabled cycle the potential leaks by an arithmetic-shift fraction.
- On crossing threshold it emits a registered spike, resets the potential and enters a refractory period.

---
 rtl/lif_neuron.sv | 195 +++++++++++++++++++
 tb/tb_lif_neuron.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron with programmable signed synaptic weights and refractory period.
// Define LIF_ADAPTIVE_THRESHOLD_EN to raise the firing threshold after each fire and let it decay back.
module lif_neuron #(
  parameter int N_IN          = 4,
  parameter int W_WIDTH       = 8,
  parameter int V_WIDTH       = 16,
  parameter int LEAK_SHIFT    = 3,
  parameter int V_THRESH      = 100,
  parameter int V_RESET       = 0,
  parameter int REFRAC_CYCLES = 4,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     enable,
  input  logic [N_IN-1:0]                          spike_in,
  input  logic [N_IN-1:0]                          spike_valid_in,
  input  logic                                     w_wr_en,
  input  logic [((N_IN > 1) ? $clog2(N_IN) : 1)-1:0] w_wr_addr,
  input  logic signed [W_WIDTH-1:0]                w_wr_data,
  output logic                                     spike_out,
  output logic                                     spike_valid,
  output logic signed [V_WIDTH-1:0]                v_mem,
  output logic                                     refractory,
  output logic [CNT_WIDTH-1:0]                     fire_count
);

  localparam int IW   = V_WIDTH + $clog2(N_IN) + 2;
  localparam int RC_W = (REFRAC_CYCLES > 0) ? $clog2(REFRAC_CYCLES + 1) : 1;
  localparam logic signed [V_WIDTH-1:0] V_RESET_V  = V_WIDTH'(V_RESET);
  localparam logic signed [V_WIDTH-1:0] V_THRESH_V = V_WIDTH'(V_THRESH);
  localparam logic signed [IW-1:0] V_MAX_W = {{(IW-V_WIDTH+1){1'b0}}, {(V_WIDTH-1){1'b1}}};
  localparam logic signed [IW-1:0] V_MIN_W = {{(IW-V_WIDTH+1){1'b1}}, {(V_WIDTH-1){1'b0}}};

  typedef enum logic [0:0] {
    ST_INTEGRATE  = 1'b0,
    ST_REFRACTORY = 1'b1
  } state_t;

  function automatic logic signed [IW-1:0] sext_v(input logic signed [V_WIDTH-1:0] x);
    return {{(IW-V_WIDTH){x[V_WIDTH-1]}}, x};
  endfunction

  function automatic logic signed [IW-1:0] sext_w(input logic signed [W_WIDTH-1:0] x);
    return {{(IW-W_WIDTH){x[W_WIDTH-1]}}, x};
  endfunction

  state_t                      state_r, state_next_s;
  logic signed [W_WIDTH-1:0]   weight_r [N_IN];
  logic [RC_W-1:0]             refrac_cnt_r, cnt_next_s;
  logic signed [IW-1:0]        syn_sum_s, v_wide_s, thresh_eff_s;
  logic signed [V_WIDTH-1:0]   leak_s, v_sat_s, v_next_s;
  logic                        fire_s, spike_next_s, refr_next_s;
  logic [CNT_WIDTH-1:0]        fc_next_s;

`ifdef LIF_ADAPTIVE_THRESHOLD_EN
  localparam int TH_W = V_WIDTH - 1;
  localparam logic [TH_W-1:0] TH_STEP = TH_W'(16);
  localparam logic [TH_W-1:0] TH_MAX  = TH_W'(255);
  logic [TH_W-1:0] th_adapt_r, th_next_s;
`endif

  // Synaptic current, leak, saturation and threshold comparison.
  always_comb begin
    syn_sum_s = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (spike_in[i] && spike_valid_in[i]) begin
        syn_sum_s = syn_sum_s + sext_w(weight_r[i]);
      end else begin
        syn_sum_s = syn_sum_s;
      end
    end
    leak_s   = v_mem >>> LEAK_SHIFT;
    v_wide_s = sext_v(v_mem) - sext_v(leak_s) + syn_sum_s;
    if (v_wide_s > V_MAX_W) begin
      v_sat_s = V_MAX_W[V_WIDTH-1:0];
    end else if (v_wide_s < V_MIN_W) begin
      v_sat_s = V_MIN_W[V_WIDTH-1:0];
    end else begin
      v_sat_s = v_wide_s[V_WIDTH-1:0];
    end
`ifdef LIF_ADAPTIVE_THRESHOLD_EN
    thresh_eff_s = sext_v(V_THRESH_V) + {{(IW-TH_W){1'b0}}, th_adapt_r};
`else
    thresh_eff_s = sext_v(V_THRESH_V);
`endif
    fire_s = (sext_v(v_sat_s) >= thresh_eff_s);
  end

  // Next-state and next-output logic; a disabled cycle holds everything but the spike strobes.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = refrac_cnt_r;
    v_next_s     = v_mem;
    spike_next_s = 1'b0;
    refr_next_s  = refractory;
    fc_next_s    = fire_count;
`ifdef LIF_ADAPTIVE_THRESHOLD_EN
    th_next_s    = th_adapt_r;
`endif
    if (enable) begin
      case (state_r)
        ST_INTEGRATE: begin
          if (fire_s) begin
            spike_next_s = 1'b1;
            v_next_s     = V_RESET_V;
            fc_next_s    = (&fire_count) ? fire_count : fire_count + CNT_WIDTH'(1);
`ifdef LIF_ADAPTIVE_THRESHOLD_EN
            th_next_s    = (th_adapt_r >= TH_MAX - TH_STEP) ? TH_MAX : th_adapt_r + TH_STEP;
`endif
            if (REFRAC_CYCLES > 0) begin
              state_next_s = ST_REFRACTORY;
              cnt_next_s   = RC_W'(REFRAC_CYCLES);
              refr_next_s  = 1'b1;
            end else begin
              state_next_s = ST_INTEGRATE;
              cnt_next_s   = '0;
              refr_next_s  = 1'b0;
            end
          end else begin
            v_next_s = v_sat_s;
`ifdef LIF_ADAPTIVE_THRESHOLD_EN
            th_next_s = (th_adapt_r != '0) ? th_adapt_r - TH_W'(1) : th_adapt_r;
`endif
          end
        end
        ST_REFRACTORY: begin
          v_next_s = V_RESET_V;
          if (refrac_cnt_r <= RC_W'(1)) begin
            state_next_s = ST_INTEGRATE;
            cnt_next_s   = '0;
            refr_next_s  = 1'b0;
          end else begin
            cnt_next_s = refrac_cnt_r - RC_W'(1);
          end
        end
        default: begin
          state_next_s = ST_INTEGRATE;
          cnt_next_s   = '0;
          refr_next_s  = 1'b0;
        end
      endcase
    end else begin
      spike_next_s = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_INTEGRATE;
      refrac_cnt_r <= '0;
      spike_out    <= 1'b0;
      spike_valid  <= 1'b0;
      v_mem        <= V_RESET_V;
      refractory   <= 1'b0;
      fire_count   <= '0;
    end else begin
      state_r      <= state_next_s;
      refrac_cnt_r <= cnt_next_s;
      spike_out    <= spike_next_s;
      spike_valid  <= enable;
      v_mem        <= v_next_s;
      refractory   <= refr_next_s;
      fire_count   <= fc_next_s;
    end
  end

  // Weight table; writes land after this cycle's integration has read the old value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_IN; i++) begin
        weight_r[i] <= '0;
      end
    end else if (w_wr_en && (int'(w_wr_addr) < N_IN)) begin
      weight_r[w_wr_addr] <= w_wr_data;
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        weight_r[i] <= weight_r[i];
      end
    end
  end

`ifdef LIF_ADAPTIVE_THRESHOLD_EN
  // Adaptive threshold offset register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      th_adapt_r <= '0;
    end else begin
      th_adapt_r <= th_next_s;
    end
  end
`endif

endmodule

// File: tb/tb_lif_neuron.sv
// Self-checking bench for lif_neuron: directed steps plus randomized traffic against an arithmetic model.
module tb_lif_neuron;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic [3:0] spike_in = '0;
  logic [3:0] spike_valid_in = '0;
  logic w_wr_en = 1'b0;
  logic [1:0] w_wr_addr = '0;
  logic signed [7:0] w_wr_data = '0;
  logic spike_out, spike_valid, refractory;
  logic signed [15:0] v_mem;
  logic [15:0] fire_count;

  logic o_en = 1'b0;
  logic o_wr_en = 1'b0;
  logic [4:0] o_sp = '0;
  logic [4:0] o_vl = '0;
  logic [2:0] o_addr = '0;
  logic signed [7:0] o_data = '0;
  logic o_spike, o_valid, o_refr;
  logic signed [15:0] o_v;
  logic [15:0] o_fc;

  int checks = 0;
  int failures = 0;

  int m_v, m_refr, m_fc, m_th;
  int m_w[4];
  int m_spike, m_valid;

  lif_neuron dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .spike_in(spike_in),
    .spike_valid_in(spike_valid_in), .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr),
    .w_wr_data(w_wr_data), .spike_out(spike_out), .spike_valid(spike_valid),
    .v_mem(v_mem), .refractory(refractory), .fire_count(fire_count)
  );

  lif_neuron #(.N_IN(5)) u_oor (
    .clk(clk), .rst_n(rst_n), .enable(o_en), .spike_in(o_sp),
    .spike_valid_in(o_vl), .w_wr_en(o_wr_en), .w_wr_addr(o_addr),
    .w_wr_data(o_data), .spike_out(o_spike), .spike_valid(o_valid),
    .v_mem(o_v), .refractory(o_refr), .fire_count(o_fc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int floor_div8(input int v);
    if (v >= 0) return v / 8;
    return -((-v + 7) / 8);
  endfunction

  task automatic model_reset();
    m_v = 0; m_refr = 0; m_fc = 0; m_th = 0; m_spike = 0; m_valid = 0;
    for (int i = 0; i < 4; i++) m_w[i] = 0;
  endtask

  task automatic model_step(input bit en, input logic [3:0] sp, input logic [3:0] vl,
                            input bit we, input int wa, input int wd);
    int cur, vn;
    cur = 0;
    if (en) begin
      m_valid = 1;
      if (m_refr > 0) begin
        m_refr--; m_spike = 0; m_v = 0;
      end else begin
        for (int i = 0; i < 4; i++) if (sp[i] && vl[i]) cur += m_w[i];
        vn = m_v - floor_div8(m_v) + cur;
        if (vn > 32767) vn = 32767;
        if (vn < -32768) vn = -32768;
        if (vn >= 100 + m_th) begin
          m_spike = 1; m_v = 0; m_refr = 4;
          if (m_fc < 65535) m_fc++;
`ifdef LIF_ADAPTIVE_THRESHOLD_EN
          m_th = (m_th + 16 > 255) ? 255 : m_th + 16;
`endif
        end else begin
          m_spike = 0; m_v = vn;
`ifdef LIF_ADAPTIVE_THRESHOLD_EN
          if (m_th > 0) m_th--;
`endif
        end
      end
    end else begin
      m_spike = 0; m_valid = 0;
    end
    if (we && wa < 4) m_w[wa] = wd;
  endtask

  task automatic chk_all();
    chk("spike_out", spike_out, m_spike);
    chk("spike_valid", spike_valid, m_valid);
    chk("v_mem", v_mem, m_v);
    chk("refractory", refractory, (m_refr > 0) ? 1 : 0);
    chk("fire_count", fire_count, m_fc);
  endtask

  task automatic cyc(input bit en, input logic [3:0] sp, input logic [3:0] vl,
                     input bit we = 1'b0, input int wa = 0, input int wd = 0);
    enable = en; spike_in = sp; spike_valid_in = vl;
    w_wr_en = we; w_wr_addr = 2'(wa); w_wr_data = 8'(wd);
    @(posedge clk);
    model_step(en, sp, vl, we, wa, wd);
    #1;
    chk_all();
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0; enable = 1'b1; spike_in = 4'hF; spike_valid_in = 4'hF; w_wr_en = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_reset();
      #1;
      chk_all();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    // 1. reset with enable and spikes active, then release
    do_reset(2);
    chk("rst_v_mem", v_mem, 0);
    chk("rst_valid", spike_valid, 0);
    cyc(1'b1, 4'h0, 4'hF);
    chk("rel_valid", spike_valid, 1);

    // 2. integrate-and-fire with w[0]=40
    cyc(1'b0, 4'h0, 4'h0, 1'b1, 0, 40);
    cyc(1'b1, 4'h1, 4'hF); chk("t2_v1", v_mem, 40);
    cyc(1'b1, 4'h1, 4'hF); chk("t2_v2", v_mem, 75);
    cyc(1'b1, 4'h1, 4'hF); chk("t2_fire", spike_out, 1); chk("t2_vrst", v_mem, 0);
    chk("t2_fc", fire_count, 1); chk("t2_refr", refractory, 1);
    cyc(1'b1, 4'h1, 4'hF); cyc(1'b1, 4'h1, 4'hF); cyc(1'b1, 4'h1, 4'hF);
    chk("t2_refr3", refractory, 1);
    cyc(1'b1, 4'h1, 4'hF); chk("t2_refr_end", refractory, 0); chk("t2_hold", v_mem, 0);
    cyc(1'b1, 4'h1, 4'hF); chk("t2_resume", v_mem, 40);
    cyc(1'b1, 4'h1, 4'hF); chk("t2_resume2", v_mem, 75);
    cyc(1'b1, 4'h1, 4'hF);
`ifdef LIF_ADAPTIVE_THRESHOLD_EN
    chk("t6_nofire", spike_out, 0); chk("t6_v", v_mem, 106);
    cyc(1'b1, 4'h1, 4'hF); chk("t6_fire2", spike_out, 1); chk("t6_fc", fire_count, 2);
`else
    chk("t2_fire2", spike_out, 1); chk("t2_fc2", fire_count, 2);
`endif

    // 3. leak of a positive value and inhibition
    do_reset(1);
    cyc(1'b0, 4'h0, 4'h0, 1'b1, 1, 80);
    cyc(1'b1, 4'h2, 4'hF); chk("t3_v80", v_mem, 80);
    cyc(1'b1, 4'h0, 4'hF); chk("t3_v70", v_mem, 70);
    cyc(1'b1, 4'h0, 4'hF); chk("t3_v62", v_mem, 62);
    cyc(1'b1, 4'h0, 4'hF); chk("t3_v55", v_mem, 55);
    do_reset(1);
    cyc(1'b0, 4'h0, 4'h0, 1'b1, 2, -50);
    cyc(1'b1, 4'h4, 4'h3); chk("t3_invalid", v_mem, 0);
    cyc(1'b1, 4'h4, 4'hF); chk("t3_vm50", v_mem, -50);
    cyc(1'b1, 4'h0, 4'hF); chk("t3_vm43", v_mem, -43);

    // 4. enable gating mid-refractory
    do_reset(1);
    cyc(1'b0, 4'h0, 4'h0, 1'b1, 0, 40);
    repeat (3) cyc(1'b1, 4'h1, 4'hF);
    chk("t4_fire", spike_out, 1);
    repeat (5) cyc(1'b0, 4'h1, 4'hF);
    chk("t4_refr_hold", refractory, 1); chk("t4_v0", v_mem, 0); chk("t4_nvalid", spike_valid, 0);
    repeat (3) cyc(1'b1, 4'h1, 4'hF);
    chk("t4_refr_left", refractory, 1);
    cyc(1'b1, 4'h1, 4'hF); chk("t4_refr_done", refractory, 0);
    cyc(1'b1, 4'h1, 4'hF); chk("t4_resume", v_mem, 40);

    // 5. weight write colliding with integration, and out-of-range addresses
    do_reset(1);
    cyc(1'b0, 4'h0, 4'h0, 1'b1, 0, 40);
    cyc(1'b1, 4'h1, 4'hF, 1'b1, 0, -20); chk("t5_old_w", v_mem, 40);
    cyc(1'b1, 4'h1, 4'hF); chk("t5_new_w", v_mem, 15);
    o_wr_en = 1'b1; o_data = 8'sd100;
    for (int a = 5; a < 8; a++) begin
      o_addr = 3'(a);
      cyc(1'b0, 4'h0, 4'h0);
    end
    o_wr_en = 1'b0; o_en = 1'b1; o_sp = 5'h1F; o_vl = 5'h1F;
    cyc(1'b0, 4'h0, 4'h0);
    chk("t5_oor_v", o_v, 0); chk("t5_oor_spk", o_spike, 0);
    o_en = 1'b0; o_wr_en = 1'b1; o_addr = 3'd4; o_data = 8'sd30;
    cyc(1'b0, 4'h0, 4'h0);
    o_wr_en = 1'b0; o_en = 1'b1; o_sp = 5'h10;
    cyc(1'b0, 4'h0, 4'h0);
    chk("t5_addr4", o_v, 30);
    o_en = 1'b0;

    // randomized traffic against the model
    do_reset(1);
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset(1);
      end else begin
        cyc(($urandom_range(0, 7) != 0), 4'($urandom), 4'($urandom),
            ($urandom_range(0, 5) == 0), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 200)) - 80);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
